// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encoding, common widths and the
// frame-time helper also used by uart_hs.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned GID_W  = 3;
    localparam int unsigned SENT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    // Clock cycles per UART frame; integer division happens before the multiply.
    function automatic int unsigned frame_cycles(input int unsigned clk_hz,
                                                 input int unsigned bps,
                                                 input int unsigned bits);
        return (clk_hz / bps) * bits;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request after last_i,
// wrapping modulo NUM_REQ. Reusable by other round-robin arbiters.
module rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GID_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_c_o,
    output logic [GID_W-1:0]   idx_c_o,
    output logic               any_c_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    always_comb begin
        int unsigned pos;
        pos     = 0;
        gnt_c_o = '0;
        idx_c_o = last_i;
        any_c_o = 1'b0;
        // Offsets 1..NUM_REQ so the last grantee is considered last.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos = (32'(last_i) + k) % NUM_REQ;
            if (!any_c_o && req_i[IDX_W'(pos)]) begin
                any_c_o               = 1'b1;
                gnt_c_o[IDX_W'(pos)]  = 1'b1;
                idx_c_o               = GID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the uart_hs transmitter among NUM_REQ byte producers,
// pacing sends by one frame time. UART_TX_ARB_CNT_EN adds the sent_cnt port.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned UART_BPS   = 115200,
    parameter int unsigned FRAME_BITS = 10
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       uart_send,
    output logic [BYTE_W-1:0]          uart_data_in,
    output logic                       tx_busy,
    output logic [GID_W-1:0]           grant_id
`ifdef UART_TX_ARB_CNT_EN
    ,
    output logic [SENT_W-1:0]          sent_cnt
`endif
);

    localparam int unsigned FRAME_CYCLES = frame_cycles(CLK_FREQ, UART_BPS, FRAME_BITS);
    localparam int unsigned CNT_W        = ($clog2(FRAME_CYCLES) < 1) ? 1 : $clog2(FRAME_CYCLES);
    localparam int unsigned WAIT_LAST    = FRAME_CYCLES - 2;

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GID_W-1:0]    gid_q, gid_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                send_q, send_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [GID_W-1:0]    pick_idx;
    logic                pick_any;
    logic [BYTE_W-1:0]   data_sel;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req_valid),
        .last_i  (gid_q),
        .gnt_c_o (pick_gnt),
        .idx_c_o (pick_idx),
        .any_c_o (pick_any)
    );

    // One-hot AND-OR mux of the winning requester's byte.
    always_comb begin
        data_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                data_sel = data_sel | req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gid_d     = gid_q;
        data_d    = data_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = pick_gnt;
                if (pick_any) begin
                    gid_d   = pick_idx;
                    data_d  = data_sel;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Leaving at FRAME_CYCLES-2 gives strobe spacing of FRAME_CYCLES+1.
                if (cnt_q == CNT_W'(WAIT_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        send_d = (state_d == ST_SEND);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gid_q   <= GID_W'(NUM_REQ - 1);
            data_q  <= '0;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            send_q  <= send_d;
            busy_q  <= busy_d;
        end
    end

    assign uart_send    = send_q;
    assign uart_data_in = data_q;
    assign tx_busy      = busy_q;
    assign grant_id     = gid_q;

`ifdef UART_TX_ARB_CNT_EN
    logic [SENT_W-1:0] sent_cnt_q;

    // Free-running count of strobed bytes; wraps naturally at 16 bits.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sent_cnt_q <= '0;
        end else if (send_q) begin
            sent_cnt_q <= sent_cnt_q + SENT_W'(1);
        end
    end

    assign sent_cnt = sent_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLK_FREQ=1000, UART_BPS=100 (frame = 100 cycles).
module tb_uart_tx_arbiter;

    localparam int unsigned FC      = 100;
    localparam int unsigned SPACING = FC + 1;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  req_valid = 4'h0;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_ready;
    logic        uart_send;
    logic [7:0]  uart_data_in;
    logic        tx_busy;
    logic [2:0]  grant_id;
`ifdef UART_TX_ARB_CNT_EN
    logic [15:0] sent_cnt;
`endif

    uart_tx_arbiter #(
        .NUM_REQ    (4),
        .CLK_FREQ   (1000),
        .UART_BPS   (100),
        .FRAME_BITS (10)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_send    (uart_send),
        .uart_data_in (uart_data_in),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id)
`ifdef UART_TX_ARB_CNT_EN
        ,
        .sent_cnt     (sent_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int busy_len = 0;
    int last_busy_len = 0;
    int          log_cyc[$];
    logic [7:0]  log_data[$];
    logic [2:0]  log_gid[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Strobe log and tx_busy run length, sampled mid-cycle.
    always @(negedge sys_clk) begin
        cyc++;
        if (uart_send === 1'b1) begin
            log_cyc.push_back(cyc);
            log_data.push_back(uart_data_in);
            log_gid.push_back(grant_id);
        end
        if (tx_busy === 1'b1) begin
            busy_len++;
        end else if (busy_len != 0) begin
            last_busy_len = busy_len;
            busy_len = 0;
        end
    end

    // req_ready invariants, checked after the driver has settled the inputs.
    always @(negedge sys_clk) begin
        #2;
        check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
        check("ready_only_valid", 32'(req_ready & ~req_valid), 32'd0);
        if (tx_busy === 1'b1) check("ready_while_busy", 32'(req_ready), 32'd0);
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_data.delete();
        log_gid.delete();
    endtask

    task automatic do_reset();
        tick();
        sys_rst   = 1'b1;
        req_valid = 4'h0;
        repeat (3) tick();
        sys_rst = 1'b0;
        clear_log();
    endtask

    task automatic wait_strobes(input int n, input int max_cycles);
        int k = 0;
        while (log_cyc.size() < n && k < max_cycles) begin
            tick();
            k++;
        end
        check("strobe_count", 32'(log_cyc.size()), 32'(n));
    endtask

    task automatic wait_idle(input int max_cycles);
        int k = 0;
        while (tx_busy !== 1'b0 && k < max_cycles) begin
            tick();
            k++;
        end
        check("idle_timeout", 32'(tx_busy), 32'd0);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  ready;
        logic        send;
        logic [7:0]  dout;
        logic        busy;
        logic [2:0]  gid;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_g3[5];
        logic [7:0] exp_d3[5];
        logic [2:0] exp_g4[4];
        logic [7:0] exp_d4[4];
        int n_before;

        // Registered outputs in row k reflect the inputs of rows before k.
        tbl[0] = '{1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 1'b0, 3'd3};
        tbl[1] = '{1'b0, 4'b0001, 32'h0000_0041, 4'b0001, 1'b0, 8'h00, 1'b0, 3'd3};
        tbl[2] = '{1'b0, 4'b0000, 32'h0000_0041, 4'b0000, 1'b1, 8'h41, 1'b1, 3'd0};
        tbl[3] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h41, 1'b1, 3'd0};
        tbl[4] = '{1'b0, 4'b0100, 32'h0055_0000, 4'b0000, 1'b0, 8'h41, 1'b1, 3'd0};
        tbl[5] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h41, 1'b1, 3'd0};

        // Reset held for 3 cycles, then reset-state and single-request vectors.
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            sys_rst   = tbl[i].rst;
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            #1;
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            check($sformatf("v%0d_send", i), 32'(uart_send), 32'(tbl[i].send));
            check($sformatf("v%0d_data", i), 32'(uart_data_in), 32'(tbl[i].dout));
            check($sformatf("v%0d_busy", i), 32'(tx_busy), 32'(tbl[i].busy));
            check($sformatf("v%0d_gid", i), 32'(grant_id), 32'(tbl[i].gid));
        end
        wait_idle(200);
        // Busy spans SEND plus WAIT counts 0..FC-2, i.e. FC cycles; one IDLE cycle completes the spacing.
        check("single_busy_len", 32'(last_busy_len), 32'(SPACING - 1));
        check("single_strobes", 32'(log_cyc.size()), 32'd1);
        if (log_cyc.size() > 0) check("single_data", 32'(log_data[0]), 32'h41);

        // All requesters valid continuously.
        do_reset();
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        wait_strobes(5, 700);
        req_valid = 4'b0000;
        exp_g3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        exp_d3 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        if (log_cyc.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("rr_gid%0d", i), 32'(log_gid[i]), 32'(exp_g3[i]));
                check($sformatf("rr_data%0d", i), 32'(log_data[i]), 32'(exp_d3[i]));
            end
            for (int i = 1; i < 5; i++) begin
                check($sformatf("rr_spacing%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'(SPACING));
            end
        end

        // Contention raised during WAIT after req1 is granted.
        do_reset();
        req_data  = 32'h2322_2120;
        req_valid = 4'b0010;
        wait_strobes(1, 10);
        tick();
        req_valid = 4'b1011;
        wait_strobes(4, 500);
        req_valid = 4'b0000;
        exp_g4 = '{3'd1, 3'd3, 3'd0, 3'd1};
        exp_d4 = '{8'h21, 8'h23, 8'h20, 8'h21};
        if (log_cyc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("cont_gid%0d", i), 32'(log_gid[i]), 32'(exp_g4[i]));
                check($sformatf("cont_data%0d", i), 32'(log_data[i]), 32'(exp_d4[i]));
            end
        end

        // Reset at WAIT count 40.
        do_reset();
        req_data  = 32'h0000_0050;
        req_valid = 4'b0001;
        wait_strobes(1, 10);
        req_valid = 4'b0000;
        repeat (41) tick();
        check("mid_busy_before_rst", 32'(tx_busy), 32'd1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_send", 32'(uart_send), 32'd0);
        check("mid_rst_gid", 32'(grant_id), 32'd3);
        repeat (150) tick();
        check("mid_no_strobe", 32'(log_cyc.size()), 32'd1);
        req_data  = 32'h7362_0000;
        req_valid = 4'b1100;
        wait_strobes(2, 10);
        req_valid = 4'b0000;
        if (log_cyc.size() >= 2) begin
            check("mid_next_gid", 32'(log_gid[1]), 32'd2);
            check("mid_next_data", 32'(log_data[1]), 32'h62);
        end

`ifdef UART_TX_ARB_CNT_EN
        // Sent counter wrap.
        do_reset();
        check("cnt_reset", 32'(sent_cnt), 32'd0);
        force dut.sent_cnt_q = 16'hFFFF;
        tick();
        release dut.sent_cnt_q;
        tick();
        check("cnt_forced", 32'(sent_cnt), 32'hFFFF);
        req_data  = 32'h0000_0077;
        req_valid = 4'b0001;
        wait_strobes(1, 10);
        req_valid = 4'b0000;
        tick();
        check("cnt_wrap", 32'(sent_cnt), 32'd0);
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
